// File: rtl/seven_seg_scanner.sv
// Four-digit multiplexed seven-segment scanner.
// Shows a four-digit BCD value one digit per slot, with a short all-off gap at
// the start of each slot. New values only take effect at a frame boundary, so
// every frame shows a single value.
`timescale 1ns/1ps
module seven_seg_scanner #(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] bcd_in,
  input  logic        bcd_valid,
  input  logic        blank_zeros,
  input  logic [3:0]  dp_en,
  output logic [3:0]  an_n,
  output logic [6:0]  seg_n,
  output logic        dp_n,
  output logic        pending
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYCLES);

  // Scan position
  logic [CNT_W-1:0] slot_cnt_q, slot_cnt_d;
  logic [1:0]       digit_idx_q, digit_idx_d;

  // Displayed value, waiting value and its flag
  logic [15:0] disp_q, disp_d;
  logic [15:0] pend_q, pend_d;
  logic        pending_q, pending_d;

  // Registered display outputs
  logic [3:0] an_n_q, an_n_d;
  logic [6:0] seg_n_q, seg_n_d;
  logic       dp_n_q, dp_n_d;

  logic       frame_end;
  logic [3:0] nib_zero;
  logic [3:0] blank_mask;
  logic [3:0] cur_nib;

  // Active-low segment pattern {g,f,e,d,c,b,a}; non-decimal nibbles show a dash.
  function automatic logic [6:0] seg_decode(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h3F;
    endcase
    return s;
  endfunction

  // Per-nibble zero flags of the displayed value
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_nib_zero
      assign nib_zero[gi] = (disp_q[4*gi +: 4] == 4'd0);
    end
  endgenerate

  // Leading-zero blanking: a digit blanks only if it and all higher digits are zero;
  // the rightmost digit always shows.
  always_comb begin
    blank_mask    = 4'b0000;
    blank_mask[3] = blank_zeros & nib_zero[3];
    blank_mask[2] = blank_mask[3] & nib_zero[2];
    blank_mask[1] = blank_mask[2] & nib_zero[1];
  end

  // Slot counter and digit index advance
  always_comb begin
    slot_cnt_d  = slot_cnt_q + CNT_W'(1);
    digit_idx_d = digit_idx_q;
    if (slot_cnt_q == SLOT_LAST) begin
      slot_cnt_d  = '0;
      digit_idx_d = digit_idx_q + 2'd1;
    end
  end

  assign frame_end = (slot_cnt_q == SLOT_LAST) && (digit_idx_q == 2'd3);

  // Value capture: strobes park in pend_q; the display only updates at a frame end
  always_comb begin
    disp_d    = disp_q;
    pend_d    = pend_q;
    pending_d = pending_q;
    if (frame_end && bcd_valid) begin
      // A strobe landing exactly on the boundary goes straight to the display
      disp_d    = bcd_in;
      pending_d = 1'b0;
    end else if (frame_end && pending_q) begin
      disp_d    = pend_q;
      pending_d = 1'b0;
    end else if (bcd_valid) begin
      pend_d    = bcd_in;
      pending_d = 1'b1;
    end
  end

  // Output decode from the current scan state; registered below
  always_comb begin
    cur_nib = disp_q[{digit_idx_q, 2'b00} +: 4];
    an_n_d  = 4'hF;
    seg_n_d = 7'h7F;
    dp_n_d  = 1'b1;
    if (slot_cnt_q >= BLANK_END) begin
      an_n_d = ~(4'b0001 << digit_idx_q);
      if (!blank_mask[digit_idx_q]) begin
        seg_n_d = seg_decode(cur_nib);
        dp_n_d  = ~dp_en[digit_idx_q];
      end
    end
  end

  // State and output registers; reset overrides any strobe in the same cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_cnt_q  <= '0;
      digit_idx_q <= 2'd0;
      disp_q      <= 16'h0000;
      pend_q      <= 16'h0000;
      pending_q   <= 1'b0;
      an_n_q      <= 4'hF;
      seg_n_q     <= 7'h7F;
      dp_n_q      <= 1'b1;
    end else begin
      slot_cnt_q  <= slot_cnt_d;
      digit_idx_q <= digit_idx_d;
      disp_q      <= disp_d;
      pend_q      <= pend_d;
      pending_q   <= pending_d;
      an_n_q      <= an_n_d;
      seg_n_q     <= seg_n_d;
      dp_n_q      <= dp_n_d;
    end
  end

  assign an_n    = an_n_q;
  assign seg_n   = seg_n_q;
  assign dp_n    = dp_n_q;
  assign pending = pending_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Scoreboard bench for seven_seg_scanner with an 8-cycle slot, 2 blank cycles.
// Stimulus pushes per-cycle expectations tagged with a cycle number; the monitor
// pops and compares on each falling edge whose cycle number matches.
`timescale 1ns/1ps
module tb_seven_seg_scanner;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] bcd_in;
  logic        bcd_valid;
  logic        blank_zeros;
  logic [3:0]  dp_en;
  logic [3:0]  an_n;
  logic [6:0]  seg_n;
  logic        dp_n;
  logic        pending;

  seven_seg_scanner #(.REFRESH_DIV(8), .BLANK_CYCLES(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .bcd_in      (bcd_in),
    .bcd_valid   (bcd_valid),
    .blank_zeros (blank_zeros),
    .dp_en       (dp_en),
    .an_n        (an_n),
    .seg_n       (seg_n),
    .dp_n        (dp_n),
    .pending     (pending)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         n;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       pend;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks   = 0;
  int   failures = 0;

  // Cycle number: -1 while in reset, 0 after the first rising edge with rst low
  int n = -100;
  always @(posedge clk) begin
    if (rst) n <= -1;
    else     n <= n + 1;
  end

  // Monitor: compare outputs against the queued expectation for this cycle
  always @(negedge clk) begin
    if (exp_q.size() > 0 && exp_q[0].n == n) begin
      mon_e = exp_q.pop_front();
      checks++;
      if (an_n !== mon_e.an || seg_n !== mon_e.seg || dp_n !== mon_e.dp || pending !== mon_e.pend) begin
        failures++;
        $display("FAIL cyc%0d: got an_n=%h seg_n=%h dp_n=%b pending=%b, want an_n=%h seg_n=%h dp_n=%b pending=%b",
                 n, an_n, seg_n, dp_n, pending, mon_e.an, mon_e.seg, mon_e.dp, mon_e.pend);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_to(input int t);
    while (n < t) tick();
  endtask

  task automatic strobe(input logic [15:0] v);
    bcd_in    = v;
    bcd_valid = 1'b1;
    tick();
    bcd_valid = 1'b0;
  endtask

  task automatic push_reset();
    exp_t e;
    e.n = -1; e.an = 4'hF; e.seg = 7'h7F; e.dp = 1'b1; e.pend = 1'b0;
    exp_q.push_back(e);
  endtask

  // Expected outputs for cycles lo..hi: s0..s3 are hand-decoded segments per digit,
  // dpm[i] is the expected dp_n for digit i, pending high for plo..phi.
  task automatic push_win(input int lo, input int hi,
                          input logic [6:0] s3, input logic [6:0] s2,
                          input logic [6:0] s1, input logic [6:0] s0,
                          input logic [3:0] dpm, input int plo, input int phi);
    exp_t e;
    logic [6:0] segs [4];
    segs[0] = s0; segs[1] = s1; segs[2] = s2; segs[3] = s3;
    for (int k = lo; k <= hi; k++) begin
      int s;
      int d;
      s = k % 8;
      d = (k / 8) % 4;
      e.n    = k;
      e.pend = (k >= plo && k <= phi);
      if (s < 2) begin
        e.an = 4'hF; e.seg = 7'h7F; e.dp = 1'b1;
      end else begin
        e.an  = ~(4'b0001 << d);
        e.seg = segs[d];
        e.dp  = dpm[d];
      end
      exp_q.push_back(e);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; bcd_valid = 1'b1; bcd_in = 16'hFFFF; blank_zeros = 1'b0; dp_en = 4'b0000;
    // Reset with a coincident strobe that must be discarded
    push_reset();
    repeat (3) tick();
    push_win(0, 31, 7'h40, 7'h40, 7'h40, 7'h40, 4'b1111, 4, 30);
    rst = 1'b0; bcd_valid = 1'b0; bcd_in = 16'h0000;
    tick_to(3);  strobe(16'h1234);              // sampled at cycle 4
    tick_to(31);
    push_win(32, 95, 7'h79, 7'h24, 7'h30, 7'h19, 4'b1111, 1, 0);
    tick_to(95);
    blank_zeros = 1'b1;
    push_win(96, 127, 7'h79, 7'h24, 7'h30, 7'h19, 4'b1111, 100, 126);
    tick_to(99); strobe(16'h0007);
    tick_to(127);
    push_win(128, 159, 7'h7F, 7'h7F, 7'h7F, 7'h78, 4'b1111, 132, 158);
    tick_to(131); strobe(16'h0000);
    tick_to(159);
    push_win(160, 191, 7'h7F, 7'h7F, 7'h7F, 7'h40, 4'b1111, 164, 190);
    tick_to(163); strobe(16'h00A5);
    tick_to(191);
    blank_zeros = 1'b0;
    push_win(192, 223, 7'h40, 7'h40, 7'h3F, 7'h12, 4'b1111, 196, 222);
    tick_to(195); strobe(16'h1111);
    tick_to(199); strobe(16'h2222);              // last value wins
    tick_to(223);
    push_win(224, 255, 7'h24, 7'h24, 7'h24, 7'h24, 4'b1111, 1, 0);
    tick_to(254); strobe(16'h3333);              // sampled exactly on the frame boundary
    dp_en = 4'b0100;
    push_win(256, 287, 7'h30, 7'h30, 7'h30, 7'h30, 4'b1011, 260, 286);
    tick_to(259); strobe(16'h0005);
    tick_to(287);
    blank_zeros = 1'b1;
    push_win(288, 298, 7'h7F, 7'h7F, 7'h7F, 7'h12, 4'b1111, 292, 298);
    tick_to(291); strobe(16'h4444);
    tick_to(298);
    // Mid-slot reset while a value is pending
    push_reset();
    rst = 1'b1;
    tick();
    push_win(0, 31, 7'h7F, 7'h7F, 7'h7F, 7'h40, 4'b1111, 1, 0);
    rst = 1'b0;
    tick_to(33);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d unchecked entries, want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seven_seg_scanner.md
SEVEN_SEG_SCANNER -- requirements
Module: seven_seg_scanner

Interface
REQ-001 SHALL have parameter REFRESH_DIV, 100000, clocks per digit slot; legal range >= 4.
REQ-002 SHALL have parameter BLANK_CYCLES, 1000, clocks at the start of each slot during which all anodes are off; legal range 1 to REFRESH_DIV-2.
REQ-003 SHALL have port clk  input  1  system clock; all logic on its rising edge; the block's only clock.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port bcd_in  input  16  four BCD digits; [3:0] is digit 0 (rightmost), [15:12] is digit 3.
REQ-006 SHALL have port bcd_valid  input  1  one-cycle strobe; bcd_in is valid in that cycle.
REQ-007 SHALL have port blank_zeros  input  1  enables leading-zero blanking.
REQ-008 SHALL have port dp_en  input  4  decimal-point enable per digit; bit i goes to digit i.
REQ-009 SHALL have port an_n  output  4  active-low anode selects; bit i is digit i.
REQ-010 SHALL have port seg_n  output  7  active-low segments {g,f,e,d,c,b,a}.
REQ-011 SHALL have port dp_n  output  1  active-low decimal point.
REQ-012 SHALL have port pending  output  1  high while a captured value waits for the next frame boundary.

Function
REQ-013 SHALL count slot_cnt from 0 to REFRESH_DIV-1 and then wrap; at wrap, digit_idx SHALL advance 0->1->2->3->0.
REQ-014 SHALL define a frame boundary as slot_cnt==REFRESH_DIV-1 with digit_idx==3.
REQ-015 SHALL, on bcd_valid, load bcd_in into pend_reg and set pending; a later strobe in the same frame SHALL overwrite pend_reg (last value wins).
REQ-016 SHALL, at a frame boundary with pending=1, copy pend_reg to disp_reg and clear pending.
REQ-017 SHALL, when bcd_valid coincides with a frame boundary, load bcd_in straight into disp_reg and leave pending at 0.
REQ-018 SHALL never change disp_reg except at a frame boundary, so no frame mixes two values.
REQ-019 SHALL register all outputs; an_n, seg_n and dp_n SHALL reflect the slot_cnt, digit_idx and disp_reg values of the previous cycle.
REQ-020 SHALL drive an_n=4'hF, seg_n=7'h7F and dp_n=1 while slot_cnt < BLANK_CYCLES.
REQ-021 SHALL, while slot_cnt >= BLANK_CYCLES, assert only an_n[digit_idx]=0.
REQ-022 SHALL decode digits 0-9 with seg_n values 40,79,24,30,19,12,02,78,00,10 (hex).
REQ-023 SHALL decode nibbles A-F as a dash: seg_n=7'h3F.
REQ-024 SHALL, with blank_zeros=1, blank digit k (k=3..1) when nibble k and every higher nibble are 0; a blanked digit gets seg_n=7'h7F and dp_n=1, with its anode still asserted.
REQ-025 SHALL never blank digit 0.
REQ-026 SHALL drive dp_n=~dp_en[digit_idx] for an unblanked active digit.
REQ-027 SHALL sample blank_zeros and dp_en live each cycle; neither is frame-synchronised.

Reset
REQ-028 SHALL, on rst=1, clear slot_cnt, digit_idx, disp_reg, pend_reg and pending to 0.
REQ-029 SHALL, on the cycle after rst is sampled, drive an_n=4'hF, seg_n=7'h7F and dp_n=1.
REQ-030 SHALL give rst priority over bcd_valid in the same cycle and discard that strobe.
REQ-031 SHALL start scanning from digit 0, slot_cnt 0, on the first cycle rst is low.

Verification (REFRESH_DIV=8, BLANK_CYCLES=2)
REQ-032 SHALL cover: reset, bcd_in=16'h1234 with bcd_valid, run 2 frames -> slots show an_n E/D/B/7 with seg_n 19/30/24/79; each slot is 8 cycles with the first 2 all-off.
REQ-033 SHALL cover: blank_zeros=1 with 16'h0007 -> digits 3..1 show seg_n=7F with anode low, digit 0 shows 78; with 16'h0000 -> digit 0 shows 40.
REQ-034 SHALL cover: 16'h00A5 with blank_zeros=0 -> digit 1 shows 3F (dash) and digit 0 shows 12.
REQ-035 SHALL cover: strobes of 16'h1111 and then 16'h2222 mid-frame -> pending=1 and the display is unchanged until the frame boundary, after which 2222 is shown and pending=0; a strobe exactly at the boundary is shown next frame with pending staying 0.
REQ-036 SHALL cover: rst pulsed mid-slot while pending=1 -> next cycle all outputs are off and pending=0; after release, disp_reg=0 and digit 0 shows 40.
REQ-037 SHALL cover: dp_en=4'b0100 -> dp_n=0 only in digit-2 active cycles, and dp_n stays 1 when digit 2 is zero-blanked.
